// File: rtl/flit_sipo.sv
// flit_sipo: receive-side deserializer. Gathers INWIDTH-bit flits (head first,
// MSB first) into WIDTH-bit packets and queues completed packets in a small
// first-word-fall-through FIFO with a valid/ready handshake toward the node.
module flit_sipo #(
    parameter int WIDTH   = 576,
    parameter int INWIDTH = 64,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [INWIDTH-1:0] flit_in,
    input  logic               flit_valid,
    input  logic               flit_head,
    output logic               flit_ready,
    output logic [WIDTH-1:0]   pkt_out,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic               full,
    output logic               empty,
    output logic               err_abort
);

    localparam int N  = WIDTH / INWIDTH;
    localparam int CW = $clog2(N + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = $clog2(DEPTH + 1);
    // The shift register only ever holds the first N-1 flits; the last flit
    // goes straight from flit_in into the FIFO together with them.
    localparam int SW = WIDTH - INWIDTH;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      flit_cnt;
    logic [CW-1:0]      flit_cnt_next;
    logic [SW-1:0]      sreg;
    logic [SW-1:0]      sreg_next;
    logic               err_next;
    logic               accept;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   push_data;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [QW-1:0]      count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // flit_ready depends only on the registered count, never on pkt_ready
    assign full       = (count == QW'(DEPTH));
    assign empty      = (count == '0);
    assign flit_ready = !full;
    assign pkt_valid  = !empty;
    assign pkt_out    = mem[rd_ptr];
    assign accept     = flit_valid && flit_ready;
    assign pop        = pkt_valid && pkt_ready;
    assign push_data  = {sreg, flit_in};

    // State, flit counter, partial-packet shift register and error pulse
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            flit_cnt  <= '0;
            sreg      <= '0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_next;
            flit_cnt  <= flit_cnt_next;
            sreg      <= sreg_next;
            err_abort <= err_next;
        end
    end

    // Assembly FSM: a head always (re)starts a packet, a stray body flit in
    // IDLE is dropped, and the N-th flit pushes the packet in the same cycle
    always_comb begin
        state_next    = state;
        flit_cnt_next = flit_cnt;
        sreg_next     = sreg;
        err_next      = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (flit_head) begin
                        sreg_next                = '0;
                        sreg_next[INWIDTH-1:0]   = flit_in;
                        flit_cnt_next            = CW'(1);
                        state_next               = COLLECT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (flit_head) begin
                        sreg_next                = '0;
                        sreg_next[INWIDTH-1:0]   = flit_in;
                        flit_cnt_next            = CW'(1);
                        err_next                 = 1'b1;
                    end else if (flit_cnt == CW'(N - 1)) begin
                        push          = 1'b1;
                        flit_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        sreg_next     = {sreg[SW-INWIDTH-1:0], flit_in};
                        flit_cnt_next = flit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                flit_cnt_next = '0;
            end
        endcase
    end

    // Output FIFO: storage, wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_sipo.sv
// tb_flit_sipo: directed bench for the flit deserializer with hand-built packets.
module tb_flit_sipo;

    localparam int WIDTH   = 576;
    localparam int INWIDTH = 64;

    localparam logic [WIDTH-1:0] P1 = {
        64'h0003_0000_0000_0101,
        64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
        64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555,
        64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [WIDTH-1:0] P2 = {
        64'h0102_0000_1000_2000,
        64'h2000_0000_0000_0001, 64'h2000_0000_0000_0002,
        64'h2000_0000_0000_0003, 64'h2000_0000_0000_0004,
        64'h2000_0000_0000_0005, 64'h2000_0000_0000_0006,
        64'h2000_0000_0000_0007, 64'h2000_0000_0000_0008};
    localparam logic [WIDTH-1:0] P3 = {
        64'h0203_0000_3000_3333,
        64'h3000_0000_0000_0011, 64'h3000_0000_0000_0022,
        64'h3000_0000_0000_0033, 64'h3000_0000_0000_0044,
        64'h3000_0000_0000_0055, 64'h3000_0000_0000_0066,
        64'h3000_0000_0000_0077, 64'h3000_0000_0000_0088};
    localparam logic [WIDTH-1:0] P4 = {
        64'h0304_0000_4000_4444,
        64'hC4C4_0000_0000_0101, 64'hC4C4_0000_0000_0202,
        64'hC4C4_0000_0000_0303, 64'hC4C4_0000_0000_0404,
        64'hC4C4_0000_0000_0505, 64'hC4C4_0000_0000_0606,
        64'hC4C4_0000_0000_0707, 64'hC4C4_0000_0000_0808};
    localparam logic [WIDTH-1:0] PA = {
        64'h0A0A_0000_AAAA_AAAA,
        64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
        64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004,
        64'hAAAA_0000_0000_0005, 64'hAAAA_0000_0000_0006,
        64'hAAAA_0000_0000_0007, 64'hAAAA_0000_0000_0008};
    localparam logic [WIDTH-1:0] P5 = {
        64'h0B05_0000_5555_0B0B,
        64'h5B5B_0000_0000_00F1, 64'h5B5B_0000_0000_00F2,
        64'h5B5B_0000_0000_00F3, 64'h5B5B_0000_0000_00F4,
        64'h5B5B_0000_0000_00F5, 64'h5B5B_0000_0000_00F6,
        64'h5B5B_0000_0000_00F7, 64'h5B5B_0000_0000_00F8};

    logic               clk;
    logic               rst_l;
    logic [INWIDTH-1:0] flit_in;
    logic               flit_valid;
    logic               flit_head;
    logic               flit_ready;
    logic [WIDTH-1:0]   pkt_out;
    logic               pkt_valid;
    logic               pkt_ready;
    logic               full;
    logic               empty;
    logic               err_abort;

    int checks;
    int errors;

    flit_sipo #(.WIDTH(WIDTH), .INWIDTH(INWIDTH), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .flit_head  (flit_head),
        .flit_ready (flit_ready),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .full       (full),
        .empty      (empty),
        .err_abort  (err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and report misses
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present inputs from a negedge, let one posedge pass, return at the next negedge
    task automatic applyStimulus(input logic v, input logic h,
                                 input logic [INWIDTH-1:0] d, input logic r);
        flit_valid = v;
        flit_head  = h;
        flit_in    = d;
        pkt_ready  = r;
        @(negedge clk);
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        pkt_ready  = 1'b0;
    endtask

    // Send all nine flits of a packet, optionally with idle gaps between them
    task automatic sendPacket(input logic [WIDTH-1:0] p, input logic gaps,
                              input logic err_head, input logic last_ready,
                              input logic pre_valid);
        logic [INWIDTH-1:0] f;
        for (int k = 0; k < 9; k++) begin
            f = p[WIDTH-1-INWIDTH*k -: INWIDTH];
            if (gaps && k > 0) begin
                repeat ((k % 3) + 1) applyStimulus(1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
            end
            checkOutput("flit_ready", flit_ready, 1);
            if (k == 8) checkOutput("pkt_valid_before_last", pkt_valid, pre_valid);
            applyStimulus(1'b1, k == 0, f, (k == 8) ? last_ready : 1'b0);
            checkOutput("err_abort", err_abort, (k == 0) ? err_head : 1'b0);
        end
    endtask

    task automatic popPacket(input logic [WIDTH-1:0] exp, input string tag);
        checkOutput(tag, pkt_out, exp);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_l      = 1'b0;
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_in    = '0;
        pkt_ready  = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_pkt_valid", pkt_valid, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_flit_ready", flit_ready, 1);
        checkOutput("rst_err_abort", err_abort, 0);
        checkOutput("rst_pkt_out", pkt_out, '0);
        rst_l = 1'b1;
        @(negedge clk);

        $display("[TB] single packet");
        sendPacket(P1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("single_valid", pkt_valid, 1);
        checkOutput("single_pkt", pkt_out, P1);
        checkOutput("single_empty", empty, 0);
        checkOutput("single_full", full, 0);
        popPacket(P1, "single_pop");
        checkOutput("single_empty_after", empty, 1);

        $display("[TB] backpressure");
        sendPacket(P2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_full_1", full, 0);
        sendPacket(P3, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_full_2", full, 1);
        checkOutput("bp_ready_2", flit_ready, 0);
        repeat (2) begin
            applyStimulus(1'b1, 1'b1, P4[575:512], 1'b0);
            checkOutput("bp_stall_ready", flit_ready, 0);
            checkOutput("bp_stall_err", err_abort, 0);
            checkOutput("bp_stall_pkt", pkt_out, P2);
        end
        applyStimulus(1'b1, 1'b1, P4[575:512], 1'b1);
        checkOutput("bp_pop_full", full, 0);
        checkOutput("bp_pop_pkt", pkt_out, P3);
        sendPacket(P4, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_full_3", full, 1);
        popPacket(P3, "bp_order_2");
        popPacket(P4, "bp_order_3");
        checkOutput("bp_empty", empty, 1);

        $display("[TB] bubbles");
        sendPacket(P1, 1'b1, 1'b0, 1'b0, 1'b0);
        popPacket(P1, "bubble_pkt");
        checkOutput("bubble_empty", empty, 1);

        $display("[TB] mid-packet head");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, k == 0, PA[WIDTH-1-INWIDTH*k -: INWIDTH], 1'b0);
            checkOutput("abort_partial_err", err_abort, 0);
        end
        sendPacket(P5, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_valid", pkt_valid, 1);
        popPacket(P5, "abort_pkt");
        checkOutput("abort_empty", empty, 1);

        $display("[TB] orphan flit");
        sendPacket(P2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        checkOutput("orphan_err", err_abort, 1);
        checkOutput("orphan_pkt", pkt_out, P2);
        checkOutput("orphan_full", full, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("orphan_err_clear", err_abort, 0);
        sendPacket(P3, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("orphan_full_2", full, 1);
        popPacket(P2, "orphan_order_1");
        popPacket(P3, "orphan_order_2");
        checkOutput("orphan_empty", empty, 1);

        $display("[TB] simultaneous push and pop");
        sendPacket(P1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendPacket(P2, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("pp_valid", pkt_valid, 1);
        checkOutput("pp_full", full, 0);
        checkOutput("pp_pkt", pkt_out, P2);
        popPacket(P2, "pp_pop");
        checkOutput("pp_empty", empty, 1);

        $display("[TB] reset mid-operation");
        sendPacket(P1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, k == 0, P2[WIDTH-1-INWIDTH*k -: INWIDTH], 1'b0);
        end
        #2 rst_l = 1'b0;
        #1;
        checkOutput("arst_pkt_valid", pkt_valid, 0);
        checkOutput("arst_empty", empty, 1);
        checkOutput("arst_full", full, 0);
        checkOutput("arst_flit_ready", flit_ready, 1);
        checkOutput("arst_err", err_abort, 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        sendPacket(P3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_valid_after", pkt_valid, 1);
        popPacket(P3, "arst_pkt");
        checkOutput("arst_empty_after", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
